// File: rtl/uart_tx_mmio_pkg.sv
// Shared register offsets, STATUS bit positions and TX FSM encodings
// for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

    localparam logic [1:0] UartTxData   = 2'd0;
    localparam logic [1:0] UartStatus   = 2'd1;
    localparam logic [1:0] UartDivisor  = 2'd2;
    localparam logic [1:0] UartReserved = 2'd3;

    localparam int StatFull     = 0;
    localparam int StatEmpty    = 1;
    localparam int StatBusy     = 2;
    localparam int StatOverflow = 3;
    localparam int StatCountLsb = 4;

    localparam int DefaultDiv = 434;

    typedef enum logic [1:0] {
        TxIdle  = 2'd0,
        TxStart = 2'd1,
        TxData  = 2'd2,
        TxStop  = 2'd3
    } tx_state_e;

    // A divisor of 0 behaves as 1, so its reload value is also 0.
    function automatic logic [15:0] bit_reload(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty detection.
// Storage is not reset; only the pointers are.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// CPU data-bus UART transmitter: register decode, read mux,
// bit-period counter and 8N1 serialiser fed from the TX FIFO.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int CLK_DIV    = DefaultDiv,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_ce,
    input  logic        ram_we,
    input  logic [31:0] ram_addr,
    input  logic [3:0]  ram_sel,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic        txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    reg_sel;
    logic          bus_wr;
    logic          data_wr;
    logic          stat_wr;
    logic          div_wr;

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [31:0]   count_ext;
    logic [3:0]    count_sat;

    logic [15:0]   divisor_q;
    logic          overflow_q;

    tx_state_e     state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          pop;
    logic          busy;
    logic [15:0]   reload;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign reg_sel = ram_addr[3:2];
    assign bus_wr  = ram_ce & ram_we;
    assign data_wr = bus_wr & (reg_sel == UartTxData) & (|ram_sel);
    assign stat_wr = bus_wr & (reg_sel == UartStatus);
    assign div_wr  = bus_wr & (reg_sel == UartDivisor) & (&ram_sel[1:0]);

    assign unused_bits = ^{ram_addr[31:4], ram_addr[1:0],
                           ram_data_i[31:16], ram_sel[3:2]};

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr),
        .pop   (pop),
        .wdata (ram_data_i[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divisor_q  <= 16'(CLK_DIV);
            overflow_q <= 1'b0;
        end else begin
            if (div_wr) divisor_q <= ram_data_i[15:0];
            // Fullness is sampled before any same-cycle pop.
            if (data_wr && fifo_full)
                overflow_q <= 1'b1;
            else if (stat_wr && ram_data_i[StatOverflow])
                overflow_q <= 1'b0;
        end
    end

    assign reload = bit_reload(divisor_q);
    assign busy   = (state_q != TxIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TxIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        unique case (state_q)
            TxIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rdata;
                    cnt_d   = reload;
                    state_d = TxStart;
                end
            end
            TxStart: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = reload;
                    idx_d   = 3'd0;
                    state_d = TxData;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            TxData: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = reload;
                    if (idx_q == 3'd7) state_d = TxStop;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            TxStop: begin
                if (cnt_q == 16'd0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_rdata;
                        cnt_d   = reload;
                        state_d = TxStart;
                    end else begin
                        state_d = TxIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = TxIdle;
        endcase
    end

    // Derived from the state register so reset drives the line high at once.
    always_comb begin
        txd = 1'b1;
        unique case (state_q)
            TxStart: txd = 1'b0;
            TxData:  txd = shreg_q[idx_q];
            default: txd = 1'b1;
        endcase
    end

    assign count_ext = 32'(fifo_count);
    assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    always_comb begin
        status_word                           = '0;
        status_word[StatFull]                 = fifo_full;
        status_word[StatEmpty]                = fifo_empty;
        status_word[StatBusy]                 = busy;
        status_word[StatOverflow]             = overflow_q;
        status_word[StatCountLsb+3:StatCountLsb] = count_sat;
    end

    always_comb begin
        ram_data_o = '0;
        if (ram_ce && !ram_we) begin
            unique case (reg_sel)
                UartStatus:  ram_data_o = status_word;
                UartDivisor: ram_data_o = {16'd0, divisor_q};
                default:     ram_data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, frame timing,
// overflow, back-to-back frames, async reset and divisor 0.
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_ce = 1'b0;
    logic        ram_we = 1'b0;
    logic [31:0] ram_addr = '0;
    logic [3:0]  ram_sel = '0;
    logic [31:0] ram_data_i = '0;
    logic [31:0] ram_data_o;
    logic        txd;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_mmio #(
        .CLK_DIV    (434),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_sel    (ram_sel),
        .ram_data_i (ram_data_i),
        .ram_data_o (ram_data_o),
        .txd        (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_bit(input logic [7:0] b, input int i,
                                     input int div);
        int p;
        p = i / div;
        if (p == 0) return 1'b0;
        if (p >= 9) return 1'b1;
        return b[p-1];
    endfunction

    task automatic bus_write(input logic [1:0] r, input logic [31:0] d,
                             input logic [3:0] s);
        @(negedge clk);
        ram_ce     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = {28'd0, r, 2'b00};
        ram_data_i = d;
        ram_sel    = s;
        @(negedge clk);
        ram_ce = 1'b0;
        ram_we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        ram_ce   = 1'b1;
        ram_we   = 1'b0;
        ram_addr = {28'd0, r, 2'b00};
        #1;
        d = ram_data_o;
        ram_ce = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        @(negedge clk);
        n_tests++;
        if (txd !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_txd: got %b expected 1", txd);
        end
        n_tests++;
        if (ram_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata_idle: got %h expected 0", ram_data_o);
        end
        rst = 1'b1;
        @(negedge clk);
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL reset_status: got %h expected 00000002", d);
        end
        bus_read(2'd2, d);
        n_tests++;
        if (d !== 32'd434) begin
            n_fail++;
            $display("FAIL reset_divisor: got %0d expected 434", d);
        end
        bus_read(2'd0, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL txdata_read: got %h expected 0", d);
        end
        bus_read(2'd3, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reserved_read: got %h expected 0", d);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        bus_write(2'd2, 32'd4, 4'b0011);
        bus_write(2'd0, 32'h55, 4'b0001);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_tests++;
            if (txd !== exp_bit(8'h55, i, 4)) begin
                n_fail++;
                $display("FAIL single_bit%0d: got %b expected %b",
                         i, txd, exp_bit(8'h55, i, 4));
            end
        end
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h6) begin
            n_fail++;
            $display("FAIL single_busy_in_stop: got %h expected 00000006", d);
        end
        @(negedge clk);
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL single_idle_after: got %h expected 00000002", d);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int          waited;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            ram_ce     = 1'b1;
            ram_we     = 1'b1;
            ram_addr   = 32'h0;
            ram_sel    = 4'b0001;
            ram_data_i = 32'(i + 1);
            @(negedge clk);
        end
        ram_ce = 1'b0;
        ram_we = 1'b0;
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h8D) begin
            n_fail++;
            $display("FAIL overflow_status: got %h expected 0000008d", d);
        end
        bus_write(2'd1, 32'h8, 4'b0001);
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h85) begin
            n_fail++;
            $display("FAIL overflow_w1c: got %h expected 00000085", d);
        end
        waited = 0;
        d = '0;
        while (waited < 2000) begin
            @(negedge clk);
            bus_read(2'd1, d);
            if (d == 32'h2) break;
            waited++;
        end
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL overflow_drain: got %h expected 00000002", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  b;
        @(negedge clk);
        ram_ce     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = 32'h0;
        ram_sel    = 4'b0001;
        ram_data_i = 32'hA5;
        @(negedge clk);
        ram_data_i = 32'h3C;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            ram_ce = 1'b0;
            ram_we = 1'b0;
            b = (i < 40) ? 8'hA5 : 8'h3C;
            n_tests++;
            if (txd !== exp_bit(b, i % 40, 4)) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: got %b expected %b",
                         i, txd, exp_bit(b, i % 40, 4));
            end
        end
        @(negedge clk);
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL b2b_idle_after: got %h expected 00000002", d);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        int          bad;
        @(negedge clk);
        ram_ce   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = 32'h0;
        ram_sel  = 4'b0001;
        ram_data_i = 32'h00;
        @(negedge clk);
        ram_data_i = 32'h11;
        @(negedge clk);
        ram_data_i = 32'h22;
        @(negedge clk);
        ram_ce = 1'b0;
        ram_we = 1'b0;
        repeat (16) @(negedge clk);
        n_tests++;
        if (txd !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_pre_txd: got %b expected 0", txd);
        end
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (txd !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_txd_now: got %b expected 1", txd);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL areset_no_frame: got %0d low samples expected 0", bad);
        end
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL areset_status: got %h expected 00000002", d);
        end
        bus_read(2'd2, d);
        n_tests++;
        if (d !== 32'd434) begin
            n_fail++;
            $display("FAIL areset_divisor: got %0d expected 434", d);
        end
    endtask

    task automatic test_div0();
        logic [31:0] d;
        bus_write(2'd2, 32'd0, 4'b0011);
        bus_read(2'd2, d);
        n_tests++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL div0_readback: got %0d expected 0", d);
        end
        bus_write(2'd2, 32'd7, 4'b0001);
        bus_read(2'd2, d);
        n_tests++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL div_partial_sel: got %0d expected 0", d);
        end
        bus_write(2'd0, 32'hFF, 4'b0001);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (txd !== exp_bit(8'hFF, i, 1)) begin
                n_fail++;
                $display("FAIL div0_bit%0d: got %b expected %b",
                         i, txd, exp_bit(8'hFF, i, 1));
            end
        end
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h6) begin
            n_fail++;
            $display("FAIL div0_busy_in_stop: got %h expected 00000006", d);
        end
        @(negedge clk);
        bus_read(2'd1, d);
        n_tests++;
        if (d !== 32'h2) begin
            n_fail++;
            $display("FAIL div0_idle_after: got %h expected 00000002", d);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_div0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
